// File: rtl/imm_extend_unit_pkg.sv
// Shared immediate-extension definitions: mode encodings and default widths.
package imm_pkg;

    localparam int unsigned IMM_IN_W  = 16;
    localparam int unsigned IMM_OUT_W = 32;
    localparam int unsigned IMM_MODE_W = 2;

    typedef logic [IMM_MODE_W-1:0] imm_mode_t;

    localparam imm_mode_t IMM_SEXT      = 2'd0;
    localparam imm_mode_t IMM_ZEXT      = 2'd1;
    localparam imm_mode_t IMM_UPPER     = 2'd2;
    localparam imm_mode_t IMM_SEXT_SHL2 = 2'd3;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Decode-side bus of the immediate extension stage.
// master: the pipeline front end driving immediates; slave: imm_extend_unit.
interface imm_extend_unit_if
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) ();

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [IN_W-1:0]   imm;
    imm_mode_t         mode;
    logic [OUT_W-1:0]  pc_next;
    logic              ext_valid;
    logic [OUT_W-1:0]  ext;
    logic              tgt_valid;
    logic [OUT_W-1:0]  tgt;

    modport master (
        output stall, flush, in_valid, imm, mode, pc_next,
        input  ext_valid, ext, tgt_valid, tgt
    );

    modport slave (
        input  stall, flush, in_valid, imm, mode, pc_next,
        output ext_valid, ext, tgt_valid, tgt
    );

endinterface

// File: rtl/imm_extend_unit_ext_core.sv
// imm_ext_core: combinational IN_W-to-OUT_W immediate widening mux.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_t        i_mode,
    output logic [OUT_W-1:0] o_ext_c
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

    // Select the widened form; SEXT_SHL2 drops the top two sign bits.
    always_comb begin
        o_ext_c = w_sext;
        case (i_mode)
            IMM_SEXT:      o_ext_c = w_sext;
            IMM_ZEXT:      o_ext_c = {{(OUT_W-IN_W){1'b0}}, i_imm};
            IMM_UPPER:     o_ext_c = {i_imm, {(OUT_W-IN_W){1'b0}}};
            IMM_SEXT_SHL2: o_ext_c = {w_sext[OUT_W-3:0], 2'b00};
            default:       o_ext_c = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extension with valid/stall/flush,
// plus an optional second stage computing pc_next + (sext(imm) << 2).
// Optional branch-target stage enabled by defining IMM_BRANCH_TARGET_EN.
module imm_extend_unit
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    imm_extend_unit_if.slave bus
);

    // Width sanity: the shift-by-2 form needs two bits of headroom.
    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_extend_unit: OUT_W must be >= IN_W + 2");
    end

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_ext;
    logic             r_ext_valid;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ext_core (
        .i_imm   (bus.imm),
        .i_mode  (bus.mode),
        .o_ext_c (w_ext)
    );

    // S1: extended immediate and its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext       <= '0;
            r_ext_valid <= 1'b0;
        end else if (bus.flush) begin
            r_ext       <= '0;
            r_ext_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_ext       <= w_ext;
            r_ext_valid <= bus.in_valid;
        end
    end

    assign bus.ext       = r_ext;
    assign bus.ext_valid = r_ext_valid;

`ifdef IMM_BRANCH_TARGET_EN
    logic [OUT_W-1:0] r_s1_pc;
    logic [IN_W-1:0]  r_s1_imm;
    logic [OUT_W-1:0] w_off;
    logic [OUT_W-1:0] r_tgt;
    logic             r_tgt_valid;

    imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_off_core (
        .i_imm   (r_s1_imm),
        .i_mode  (IMM_SEXT_SHL2),
        .o_ext_c (w_off)
    );

    // S1 copies of pc_next and the raw immediate feeding the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_pc  <= '0;
            r_s1_imm <= '0;
        end else if (!bus.flush && !bus.stall) begin
            r_s1_pc  <= bus.pc_next;
            r_s1_imm <= bus.imm;
        end
    end

    // S2: branch target, wrapping modulo 2^OUT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt       <= '0;
            r_tgt_valid <= 1'b0;
        end else if (bus.flush) begin
            r_tgt       <= '0;
            r_tgt_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_tgt       <= r_s1_pc + w_off;
            r_tgt_valid <= r_ext_valid;
        end
    end

    assign bus.tgt       = r_tgt;
    assign bus.tgt_valid = r_tgt_valid;
`else
    logic w_unused_pc;

    assign w_unused_pc   = ^bus.pc_next;
    assign bus.tgt       = '0;
    assign bus.tgt_valid = 1'b0;
`endif

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised immediate-generation stage for the pipeline's decode/execute boundary. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper-load or sign-extend-shift-left-2. It registers the result with valid/stall/flush control, and can optionally compute a registered PC-relative branch target one cycle later. It replaces the fixed 16-to-32 sign-extension register in the ID stage.

## Interface
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + 2
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all pipeline registers
- flush  in  1  kill in-flight entries
- in_valid  in  1  imm/mode/pc_next qualify this cycle
- imm  in  IN_W  raw immediate field
- mode  in  2  extension mode (see Operation)
- pc_next  in  OUT_W  PC+4 of the instruction (used only with IMM_BRANCH_TARGET_EN)
- ext_valid  out  1  ext holds a valid result
- ext  out  OUT_W  extended immediate
- tgt_valid  out  1  tgt holds a valid branch target (tied 0 without the macro)
- tgt  out  OUT_W  branch target (tied 0 without the macro)

## Operation
- Modes:
  - 0 SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - 1 ZEXT: {(OUT_W-IN_W){0}, imm}
  - 2 UPPER: imm placed in the top IN_W bits, low OUT_W-IN_W bits zero
  - 3 SEXT_SHL2: SEXT result shifted left 2, low 2 bits zero, top 2 bits discarded
- Stage 1 (S1) registers ext, ext_valid, and the S1 copy of pc_next.
- Stage 2 (S2), present only with the macro: tgt = S1 pc_next + (S1 SEXT_SHL2 of the S1 immediate), computed modulo 2^OUT_W.
  - S2 always uses the SEXT_SHL2 form of the S1 immediate, independent of mode.
  - S1 therefore also keeps the raw immediate.
- Advance rule: with stall=0 and flush=0, S1 loads in_valid and the new data, and S2 loads ext_valid and S1 data. Invalid entries still load data; data is don't-care while its valid is 0.
- Stall: every register holds its value, valids included.
- Flush: ext_valid and tgt_valid clear on the next edge, and ext and tgt clear to 0. Flush overrides stall. An input presented in the same cycle as flush is dropped.
- Parameter check: an elaboration-time error is raised if OUT_W < IN_W + 2.

## Timing
- Reset: ext=0, ext_valid=0, tgt=0, tgt_valid=0, internal S1 pc/imm copies=0. Reset overrides flush and stall.
- Latency: ext is 1 cycle after in_valid; tgt is 2 cycles after in_valid.
- Throughput: one input per cycle while stall=0. No backpressure output; upstream must observe stall itself.
- Reset asserted mid-operation discards all in-flight entries on the next edge.
- Stall released: the pipeline resumes from the held state with no duplicated or lost entries.
- Branch-target wrap-around: the sum wraps silently; no overflow flag.

## Configuration
- IMM_BRANCH_TARGET_EN defined: S2 adder and registers are present, and S1 keeps pc_next and the raw immediate.
- IMM_BRANCH_TARGET_EN undefined: no S2 logic and no pc/imm storage. tgt and tgt_valid are tied to 0, and pc_next is ignored.
- S1 behaviour is identical in both configurations.

## Structure
- Shared package imm_pkg holds:
  - the 2-bit mode encoding constants IMM_SEXT=0, IMM_ZEXT=1, IMM_UPPER=2, IMM_SEXT_SHL2=3
  - the default width constants IMM_IN_W=16, IMM_OUT_W=32
- One natural sub-module: imm_ext_core, a combinational IN_W-to-OUT_W mode mux.
  - Instantiated once for S1 ext.
  - Instantiated once with mode tied to IMM_SEXT_SHL2 for the S2 offset.
- Top level owns all registers, the valid/stall/flush control and the adder.

## Test plan
- Reset then modes, default widths. Inputs: rst high 2 cycles, then imm=16'h8001 with mode 0/1/2/3 on consecutive cycles. Required ext, one cycle after each input: 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004.
- Branch target (macro on). Input: imm=16'hFFFF, pc_next=32'h00000100, in_valid=1. Required: 2 cycles later tgt=32'h000000FC and tgt_valid=1.
- Branch-target wrap. Input: imm=16'h0001, pc_next=32'hFFFFFFFC. Required: tgt=32'h00000000, tgt_valid=1.
- Stall hold. Input: stall for 3 cycles while S1 and S2 are valid, with in_valid toggling. Required: ext, tgt and both valids unchanged; on release, the next input appears 1 cycle later.
- Flush with stall. Input: stall=1, flush=1 and in_valid=1 in the same cycle. Required: next cycle ext_valid=0, tgt_valid=0, ext=0, tgt=0, and the input is dropped.
- Parameter sweep. Build IN_W=12, OUT_W=32 with imm=12'h800, mode 0. Required ext=32'hFFFFF800. With mode 2, required ext=32'h80000000.
